// File: rtl/mac_pkg.sv
// Shared types and the MSB-first line unpack helper for the MAC line loader.
package mac_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 8;
  localparam int LW         = DATA_WIDTH * DEPTH;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    REQ      = 3'd2,
    WAIT     = 3'd3,
    WRITE_A  = 3'd4,
    STREAM_B = 3'd5,
    DONE     = 3'd6
  } loader_state_t;

  // Element 0 occupies the most significant slot of the line.
  function automatic logic [DATA_WIDTH-1:0] line_elem(input logic [LW-1:0] line,
                                                      input int unsigned idx);
    return line[LW - 1 - idx * DATA_WIDTH -: DATA_WIDTH];
  endfunction

endpackage

// File: rtl/mac_line_loader.sv
// Loads ROWS matrix lines into the A FIFOs and streams one vector line into B,
// issuing one memory read at a time.
module mac_line_loader #(
  parameter int          DATA_WIDTH = 8,
  parameter int          DEPTH      = 8,
  parameter int          ROWS       = 8,
  parameter logic [31:0] BASE_ADDR  = 32'd0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic [31:0]                   address,
  output logic                          read,
  input  logic [DATA_WIDTH*DEPTH-1:0]   readdata,
  input  logic                          readdatavalid,
  input  logic                          waitrequest,
  output logic                          clr,
  output logic                          a_wren,
  output logic [DATA_WIDTH*DEPTH-1:0]   a_data,
  output logic                          b_wren,
  output logic [DATA_WIDTH-1:0]         b_data,
  output logic                          busy,
  output logic                          done
);
  import mac_pkg::*;

  localparam int LINE_W = DATA_WIDTH * DEPTH;
  localparam int LIW    = $clog2(ROWS + 1);
  localparam int BIW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LIW-1:0] LAST_ROW = LIW'(ROWS);
  localparam logic [BIW-1:0] LAST_B   = BIW'(DEPTH - 1);

  loader_state_t         state;
  loader_state_t         next_state;
  logic [LIW-1:0]        line_idx;
  logic [BIW-1:0]        b_idx;
  logic [LINE_W-1:0]     line_q;
  logic [DATA_WIDTH-1:0] b_elem;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; responses only count while a read is outstanding.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start) next_state = CLEAR; else next_state = IDLE;
      CLEAR:    next_state = REQ;
      REQ:      if (!waitrequest) next_state = WAIT; else next_state = REQ;
      WAIT: begin
        if (readdatavalid) begin
          if (line_idx < LAST_ROW) next_state = WRITE_A;
          else                     next_state = STREAM_B;
        end else begin
          next_state = WAIT;
        end
      end
      WRITE_A:  next_state = REQ;
      STREAM_B: if (b_idx == LAST_B) next_state = DONE; else next_state = STREAM_B;
      DONE:     if (start) next_state = CLEAR; else next_state = DONE;
      default:  next_state = IDLE;
    endcase
  end

  // Line and element counters plus the captured memory line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_idx <= {LIW{1'b0}};
      b_idx    <= {BIW{1'b0}};
      line_q   <= {LINE_W{1'b0}};
    end else begin
      case (state)
        CLEAR: begin
          line_idx <= {LIW{1'b0}};
          b_idx    <= {BIW{1'b0}};
        end
        WAIT:     if (readdatavalid) line_q <= readdata;
        WRITE_A:  line_idx <= line_idx + 1'b1;
        STREAM_B: b_idx <= b_idx + 1'b1;
        default:  ;
      endcase
    end
  end

  generate
    if (DATA_WIDTH == mac_pkg::DATA_WIDTH && DEPTH == mac_pkg::DEPTH) begin : g_pkg_unpack
      assign b_elem = line_elem(line_q, 32'(b_idx));
    end else begin : g_shift_unpack
      assign b_elem = DATA_WIDTH'(line_q >> ((DEPTH - 1 - int'(b_idx)) * DATA_WIDTH));
    end
  endgenerate

  assign address = BASE_ADDR + 32'(line_idx);
  assign read    = (state == REQ);
  assign clr     = (state == CLEAR);
  assign a_wren  = (state == WRITE_A);
  assign a_data  = (state == WRITE_A) ? line_q : {LINE_W{1'b0}};
  assign b_wren  = (state == STREAM_B);
  assign b_data  = (state == STREAM_B) ? b_elem : {DATA_WIDTH{1'b0}};
  assign busy    = (state != IDLE) && (state != DONE);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_mac_line_loader.sv
// Randomized bench: a transaction-level model predicts the A lines, B elements,
// read addresses and start-to-done latency of the loader.
module tb_mac_line_loader;
  localparam int DW = 8;
  localparam int DP = 8;
  localparam int NR = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, read, readdatavalid = 1'b0, waitrequest = 1'b0;
  logic        clr, a_wren, b_wren, busy, done;
  logic [31:0] address;
  logic [63:0] readdata = 64'd0, a_data;
  logic [7:0]  b_data;

  logic        start2 = 1'b0, read2, rdv2 = 1'b0, clr2, a_wren2, b_wren2, busy2, done2;
  logic [31:0] address2;
  logic [63:0] readdata2 = 64'd0, a_data2;
  logic [7:0]  b_data2;

  mac_line_loader #(.DATA_WIDTH(DW), .DEPTH(DP), .ROWS(NR), .BASE_ADDR(32'd0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .address(address), .read(read),
    .readdata(readdata), .readdatavalid(readdatavalid), .waitrequest(waitrequest),
    .clr(clr), .a_wren(a_wren), .a_data(a_data), .b_wren(b_wren), .b_data(b_data),
    .busy(busy), .done(done));

  mac_line_loader #(.DATA_WIDTH(DW), .DEPTH(DP), .ROWS(2), .BASE_ADDR(32'd0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .address(address2), .read(read2),
    .readdata(readdata2), .readdatavalid(rdv2), .waitrequest(1'b0),
    .clr(clr2), .a_wren(a_wren2), .a_data(a_data2), .b_wren(b_wren2), .b_data(b_data2),
    .busy(busy2), .done(done2));

  logic [63:0] mem [0:8];
  int n_checks = 0, n_err = 0, cyc = 0;

  logic        m_busy = 1'b0, m_done = 1'b0, m_clr = 1'b0;
  logic [63:0] exp_a [$];
  logic [7:0]  exp_b [$];
  logic [31:0] exp_addr [$];
  int t0 = 0, lat = 0, done_cyc = -1, b_run = 0, a_cnt = 0, b_cnt = 0, n_acc = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_addr = 32'd0, pend_addr = 32'd0;
  int pend = 0;
  int wait_pct = 0, max_lat = 1, stale_pct = 0, busy_start_pct = 0;
  int stall_line = -1, stall_left = 0;
  logic do_start = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] elem(input logic [63:0] line, input int i);
    logic [63:0] t;
    t = line >> (8 * (DP - 1 - i));
    return t[7:0];
  endfunction

  // One clock cycle: check this cycle's outputs against the model, then drive inputs.
  task automatic step();
    int l;
    @(negedge clk);
    cyc++;
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("clr", 64'(clr), 64'(m_clr));
    if (stall_prev) begin
      chk("stall_read", 64'(read), 64'd1);
      chk("stall_addr", 64'(address), 64'(stall_addr));
    end
    if (a_wren) begin
      a_cnt++;
      if (exp_a.size() == 0) chk("a_unexpected", 64'(a_wren), 64'd0);
      else                   chk("a_data", a_data, exp_a.pop_front());
    end
    if (b_wren) begin
      b_run++;
      b_cnt++;
      if (exp_b.size() == 0) chk("b_unexpected", 64'(b_wren), 64'd0);
      else                   chk("b_data", 64'(b_data), 64'(exp_b.pop_front()));
    end else begin
      if (b_run != 0) chk("b_run_len", 64'(b_run), 64'(DP));
      b_run = 0;
    end
    if (done && done_cyc < 0) begin
      done_cyc = cyc;
      chk("latency", 64'(cyc - t0), 64'(lat));
    end

    readdatavalid = 1'b0;
    readdata = {$urandom, $urandom};
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        readdatavalid = 1'b1;
        readdata = (pend_addr < 32'd9) ? mem[pend_addr] : 64'd0;
      end
    end else if ($urandom_range(0, 99) < stale_pct) begin
      readdatavalid = 1'b1;
    end
    if (read) begin
      if (stall_left > 0 && address == 32'(stall_line)) begin
        waitrequest = 1'b1;
        stall_left--;
      end else begin
        waitrequest = ($urandom_range(0, 99) < wait_pct);
      end
    end else begin
      waitrequest = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    if (do_start) begin
      start = 1'b1;
      do_start = 1'b0;
    end else if (m_busy && $urandom_range(0, 99) < busy_start_pct) begin
      start = 1'b1;
    end

    stall_prev = read && waitrequest;
    stall_addr = address;
    if (read && waitrequest) lat++;
    if (read && !waitrequest) begin
      n_acc++;
      if (exp_addr.size() == 0) chk("read_unexpected", 64'(read), 64'd0);
      else                      chk("read_addr", 64'(address), 64'(exp_addr.pop_front()));
      l = $urandom_range(1, max_lat);
      pend = l;
      pend_addr = address;
      lat += 1 + l;
    end

    m_clr = 1'b0;
    if (start && !m_busy) begin
      m_busy = 1'b1; m_done = 1'b0; m_clr = 1'b1;
      t0 = cyc; done_cyc = -1;
      lat = 1 + NR + DP + 1;
      exp_a.delete(); exp_b.delete(); exp_addr.delete();
      for (int k = 0; k < NR; k++) exp_a.push_back(mem[k]);
      for (int k = 0; k <= NR; k++) exp_addr.push_back(32'(k));
      for (int i = 0; i < DP; i++) exp_b.push_back(elem(mem[NR], i));
    end else if (m_busy && b_wren && exp_b.size() == 0) begin
      m_busy = 1'b0; m_done = 1'b1;
    end
  endtask

  task automatic run_to_done();
    int n;
    n = 0;
    do_start = 1'b1; a_cnt = 0; b_cnt = 0; n_acc = 0;
    step();
    while (done_cyc < 0 && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) chk("timeout_done", 64'(done), 64'd1);
    chk("a_count", 64'(a_cnt), 64'(NR));
    chk("b_count", 64'(b_cnt), 64'(DP));
    chk("reads_accepted", 64'(n_acc), 64'(NR + 1));
    chk("model_drained", 64'(exp_a.size() + exp_b.size() + exp_addr.size()), 64'd0);
  endtask

  initial begin
    int na2, nb2, nr2, pend2;
    logic [31:0] pa2;
    for (int k = 0; k <= NR; k++) mem[k] = 64'h0102030405060708 + 64'(k) * 64'h0808080808080808;
    chk("pin_mem3", mem[3], 64'h191A1B1C1D1E1F20);
    chk("pin_vec_e0", 64'(elem(mem[NR], 0)), 64'h41);
    chk("pin_vec_e7", 64'(elem(mem[NR], 7)), 64'h48);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();

    // Zero-wait memory, latency 1.
    run_to_done();
    chk("lat_zero_wait", 64'(done_cyc - t0), 64'd36);
    repeat (2) step();

    // Five stall cycles on line 3.
    stall_line = 3; stall_left = 5;
    run_to_done();
    chk("lat_stall5", 64'(done_cyc - t0), 64'd41);
    stall_line = -1;

    // Stale responses and start while busy.
    stale_pct = 30; busy_start_pct = 15;
    run_to_done();
    chk("lat_stale", 64'(done_cyc - t0), 64'd36);
    stale_pct = 0; busy_start_pct = 0;

    // Reset in the middle of the B stream.
    do_start = 1'b1;
    for (int n = 0; n < 300 && b_run != 3; n++) step();
    chk("reached_b3", 64'(b_run), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("rst_read", 64'(read), 64'd0);     chk("rst_clr", 64'(clr), 64'd0);
    chk("rst_a_wren", 64'(a_wren), 64'd0); chk("rst_b_wren", 64'(b_wren), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);     chk("rst_done", 64'(done), 64'd0);
    chk("rst_a_data", a_data, 64'd0);      chk("rst_b_data", 64'(b_data), 64'd0);
    chk("rst_address", 64'(address), 64'd0);
    m_busy = 1'b0; m_done = 1'b0; m_clr = 1'b0; b_run = 0; pend = 0; stall_prev = 1'b0;
    exp_a.delete(); exp_b.delete(); exp_addr.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    run_to_done();
    chk("lat_after_reset", 64'(done_cyc - t0), 64'd36);

    // Random memory contents, stalls, latencies, stale pulses and busy starts.
    wait_pct = 30; max_lat = 4; stale_pct = 20; busy_start_pct = 10;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k <= NR; k++) mem[k] = {$urandom, $urandom};
      run_to_done();
      repeat ($urandom_range(0, 3)) step();
    end

    // ROWS=2 instance: addresses 0..2, two A lines, vector from line 2.
    na2 = 0; nb2 = 0; nr2 = 0; pend2 = 0; pa2 = 32'd0;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int c = 0; c < 100 && !done2; c++) begin
      if (a_wren2) begin
        if (na2 < 2) chk("r2_a_data", a_data2, mem[na2]);
        else         chk("r2_a_extra", 64'(a_wren2), 64'd0);
        na2++;
      end
      if (b_wren2) begin
        if (nb2 < DP) chk("r2_b_data", 64'(b_data2), 64'(elem(mem[2], nb2)));
        nb2++;
      end
      rdv2 = 1'b0;
      if (pend2 != 0) begin
        rdv2 = 1'b1;
        readdata2 = (pa2 < 32'd9) ? mem[pa2] : 64'd0;
        pend2 = 0;
      end
      if (read2) begin
        chk("r2_addr", 64'(address2), 64'(nr2));
        nr2++; pend2 = 1; pa2 = address2;
      end
      @(negedge clk);
    end
    chk("r2_done", 64'(done2), 64'd1);
    chk("r2_a_count", 64'(na2), 64'd2);
    chk("r2_b_count", 64'(nb2), 64'(DP));
    chk("r2_reads", 64'(nr2), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
